// File: rtl/instr_fetch_pkg.sv
// Shared ISA package: default widths, instruction field positions
// and the opcode constants decoded by both fetch and control.
package instr_fetch_pkg;

  localparam int PC_W_DEF = 8;
  localparam int IW_DEF   = 16;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int FN_HI  = 2;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [4:0] OP_NOP      = 5'b00000;
  localparam logic [4:0] OP_HLT      = 5'b11100;
  localparam logic [4:0] OP_HLT_MASK = 5'b11100;

  // Any 111xx opcode halts the core.
  function automatic logic is_hlt(input logic [4:0] op);
    return (op & OP_HLT_MASK) == OP_HLT;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, run/single-step/halt sequencing.
// Ports: clock/reset (sync, active-high); run_mode, step_exe;
//   pc_en, jump, branch from control; imem_addr/imem_rdata to the
//   synchronous instruction memory; decoded fields opcode, rdest,
//   func, imm8; pc, ir_valid, halted status.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run_mode,
  input  logic            step_exe,
  input  logic            pc_en,
  input  logic            jump,
  input  logic            branch,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_rdata,
  output logic [4:0]      opcode,
  output logic [2:0]      rdest,
  output logic [2:0]      func,
  output logic [7:0]      imm8,
  output logic [PC_W-1:0] pc,
  output logic            ir_valid,
  output logic            halted
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_SWAIT = 3'd2;
  localparam logic [2:0] S_SEXEC = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_nxt;
  logic            step_q, step_d;

  logic [4:0]      op_raw;
  logic [PC_W-1:0] jmp_tgt, br_off;
  logic            issue, hlt, adv, step_rise;

  assign op_raw = imem_rdata[OP_HI:OP_LO];
  assign rdest  = imem_rdata[RD_HI:RD_LO];
  assign func   = imem_rdata[FN_HI:FN_LO];
  assign imm8   = imem_rdata[IMM_HI:IMM_LO];

  assign issue    = (state_q == S_RUN) || (state_q == S_SEXEC);
  assign ir_valid = issue || (state_q == S_SWAIT);
  assign halted   = (state_q == S_HALT);
  assign opcode   = (issue && !reset) ? op_raw : OP_NOP;
  assign pc       = pc_q;

  assign hlt       = is_hlt(op_raw);
  assign adv       = pc_en & ir_valid & issue;
  assign step_rise = step_exe & ~step_q;

  assign jmp_tgt = PC_W'(imm8);
  assign br_off  = PC_W'($signed(imm8));

  // Jump outranks branch; all arithmetic wraps at 2^PC_W.
  always_comb begin
    pc_nxt = pc_q;
    if (adv) begin
      if (jump) begin
        pc_nxt = jmp_tgt;
      end else if (branch) begin
        pc_nxt = pc_q + PC_W'(1) + br_off;
      end else begin
        pc_nxt = pc_q + PC_W'(1);
      end
    end
  end

  // Memory sees next-edge PC so rdata lines up with pc_q.
  assign pc_d      = reset ? '0 : pc_nxt;
  assign imem_addr = pc_d;
  assign step_d    = step_exe;

  // Mode changes only on adv, never mid multi-cycle op.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = run_mode ? S_RUN : S_SWAIT;
      S_RUN: begin
        if (hlt)                   state_d = S_HALT;
        else if (adv && !run_mode) state_d = S_SWAIT;
      end
      S_SWAIT: begin
        if (run_mode)       state_d = S_RUN;
        else if (step_rise) state_d = S_SEXEC;
      end
      S_SEXEC: begin
        if (hlt)      state_d = S_HALT;
        else if (adv) state_d = run_mode ? S_RUN : S_SWAIT;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      step_q  <= step_d;
    end
  end

endmodule
